// File: rtl/dice_cfg_pkg.sv
// Shared constants and FSM encoding for the DICE configuration loader.
package dice_cfg_pkg;
  localparam int NUM_TILES          = 16;
  localparam int TILE_BITS          = 156;
  localparam int NUM_CGRA_IO        = 32;
  localparam int PRED_BITS_PER_PORT = 8;
  localparam int GPRF_BITS_PER_PORT = 49;
  localparam int LAT_WIDTH          = 7;
  localparam int WORD_WIDTH         = 32;

  localparam int CNT_W          = 7;
  localparam int SUB_W          = 3;
  localparam int WORDS_PER_TILE = 5;
  localparam int WORDS_PER_GPRF = 2;
  localparam int SEG_CGRA_WORDS = 80;
  localparam int SEG_PRED_WORDS = 8;
  localparam int SEG_GPRF_WORDS = 64;
  localparam int SEG_LAT_WORDS  = 1;

  typedef enum logic [2:0] {
    IDLE, LD_CGRA, LD_PRED, LD_GPRF, LD_LAT, DONE, ERROR
  } state_e;
endpackage

// File: rtl/dice_cfg_loader_if.sv
// Valid/ready word stream feeding the configuration loader.
interface dice_cfg_loader_if #(parameter int WORD_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_last;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/dice_cfg_word_ctr.sv
// Segment word counter; also splits the count into unit index / word-in-unit.
module dice_cfg_word_ctr import dice_cfg_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] seg_len_i,
  input  logic [SUB_W-1:0] unit_len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [SUB_W-1:0] sub_o,
  output logic [CNT_W-1:0] idx_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, idx_q;
  logic [SUB_W-1:0] sub_q;
  logic             unit_end;

  assign tc_o     = (cnt_q == seg_len_i - CNT_W'(1));
  assign unit_end = (sub_q == unit_len_i - SUB_W'(1));
  assign cnt_o    = cnt_q;
  assign sub_o    = sub_q;
  assign idx_o    = idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      cnt_q <= '0;
      sub_q <= '0;
      idx_q <= '0;
    end else if (inc_i) begin
      if (tc_o) begin
        cnt_q <= '0;
        sub_q <= '0;
        idx_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        sub_q <= unit_end ? '0 : sub_q + SUB_W'(1);
        idx_q <= unit_end ? idx_q + CNT_W'(1) : idx_q;
      end
    end
  end
endmodule

// File: rtl/dice_cfg_loader.sv
// Streams 153 config words into tile, predicate-RF, GP-RF and latency registers.
module dice_cfg_loader import dice_cfg_pkg::*; #(
  parameter int NUM_TILES          = dice_cfg_pkg::NUM_TILES,
  parameter int TILE_BITS          = dice_cfg_pkg::TILE_BITS,
  parameter int NUM_CGRA_IO        = dice_cfg_pkg::NUM_CGRA_IO,
  parameter int PRED_BITS_PER_PORT = dice_cfg_pkg::PRED_BITS_PER_PORT,
  parameter int GPRF_BITS_PER_PORT = dice_cfg_pkg::GPRF_BITS_PER_PORT,
  parameter int LAT_WIDTH          = dice_cfg_pkg::LAT_WIDTH,
  parameter int WORD_WIDTH         = dice_cfg_pkg::WORD_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clr,
  input  logic                                      start,
  dice_cfg_loader_if.slave                          bus,
  output logic [NUM_TILES*TILE_BITS-1:0]            cgra_cfg,
  output logic [NUM_CGRA_IO*PRED_BITS_PER_PORT-1:0] predrf_cfg,
  output logic [NUM_CGRA_IO*GPRF_BITS_PER_PORT-1:0] gprf_cfg,
  output logic [LAT_WIDTH-1:0]                      cgra_compute_latency,
  output logic                                      cfg_valid,
  output logic                                      busy,
  output logic                                      err
);
  localparam int TSEL_W    = $clog2(NUM_TILES);
  localparam int PORTS_PER_W = WORD_WIDTH / PRED_BITS_PER_PORT;

  state_e state_q, state_d;
  logic   cfg_valid_q, cfg_valid_d, err_q, err_d;
  logic   busy_w, acc, we, ctr_clr, ctr_tc;
  logic [CNT_W-1:0] seg_len, ctr_cnt, ctr_idx;
  logic [SUB_W-1:0] unit_len, ctr_sub;
  logic [WORD_WIDTH-1:0] wd;

  logic [NUM_TILES-1:0][TILE_BITS-1:0]            cgra_q;
  logic [NUM_CGRA_IO-1:0][PRED_BITS_PER_PORT-1:0] pred_q;
  logic [NUM_CGRA_IO-1:0][GPRF_BITS_PER_PORT-1:0] gprf_q;
  logic [LAT_WIDTH-1:0]                           lat_q;
  logic [WORDS_PER_TILE*WORD_WIDTH-1:0]           tile_wr;

  assign wd     = bus.in_data;
  assign busy_w = (state_q == LD_CGRA) || (state_q == LD_PRED) ||
                  (state_q == LD_GPRF) || (state_q == LD_LAT);
  // Gated by rst_n so nothing looks accepted while reset is being applied.
  assign bus.in_ready = busy_w && rst_n;
  assign acc = bus.in_valid && busy_w;
  assign we  = acc && !clr;

  dice_cfg_word_ctr u_ctr (
    .clk(clk), .rst_n(rst_n), .clr_i(ctr_clr), .inc_i(we),
    .seg_len_i(seg_len), .unit_len_i(unit_len),
    .cnt_o(ctr_cnt), .sub_o(ctr_sub), .idx_o(ctr_idx), .tc_o(ctr_tc)
  );

  always_comb begin
    state_d     = state_q;
    cfg_valid_d = cfg_valid_q;
    err_d       = err_q;
    ctr_clr     = 1'b0;
    seg_len     = CNT_W'(SEG_LAT_WORDS);
    unit_len    = SUB_W'(1);
    case (state_q)
      LD_CGRA: begin seg_len = CNT_W'(SEG_CGRA_WORDS); unit_len = SUB_W'(WORDS_PER_TILE); end
      LD_PRED: seg_len = CNT_W'(SEG_PRED_WORDS);
      LD_GPRF: begin seg_len = CNT_W'(SEG_GPRF_WORDS); unit_len = SUB_W'(WORDS_PER_GPRF); end
      default: ;
    endcase
    if (clr) begin
      state_d = IDLE; cfg_valid_d = 1'b0; err_d = 1'b0; ctr_clr = 1'b1;
    end else if (start && !busy_w) begin
      state_d = LD_CGRA; cfg_valid_d = 1'b0; err_d = 1'b0; ctr_clr = 1'b1;
    end else if (acc) begin
      if (state_q == LD_LAT) begin
        if (bus.in_last) begin state_d = DONE; cfg_valid_d = 1'b1; end
        else begin state_d = ERROR; err_d = 1'b1; end
      end else if (bus.in_last) begin
        state_d = ERROR; err_d = 1'b1;
      end else if (ctr_tc) begin
        case (state_q)
          LD_CGRA: state_d = LD_PRED;
          LD_PRED: state_d = LD_GPRF;
          default: state_d = LD_LAT;
        endcase
      end
    end
  end

  // Merge the incoming word into the current tile; bits past TILE_BITS drop off.
  always_comb begin
    tile_wr = '0;
    tile_wr[TILE_BITS-1:0] = cgra_q[ctr_idx[TSEL_W-1:0]];
    tile_wr[int'(ctr_sub)*WORD_WIDTH +: WORD_WIDTH] = wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cgra_q      <= '0;
      pred_q      <= '0;
      gprf_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
      if (we) begin
        case (state_q)
          LD_CGRA: cgra_q[ctr_idx[TSEL_W-1:0]] <= tile_wr[TILE_BITS-1:0];
          LD_PRED:
            for (int i = 0; i < NUM_CGRA_IO; i++)
              if (ctr_cnt == CNT_W'(i / PORTS_PER_W))
                pred_q[i] <= wd[(i % PORTS_PER_W)*PRED_BITS_PER_PORT +: PRED_BITS_PER_PORT];
          LD_GPRF:
            for (int i = 0; i < NUM_CGRA_IO; i++)
              if (ctr_idx == CNT_W'(i)) begin
                if (ctr_sub == '0) gprf_q[i][WORD_WIDTH-1:0] <= wd;
                else gprf_q[i][GPRF_BITS_PER_PORT-1:WORD_WIDTH] <=
                       wd[GPRF_BITS_PER_PORT-WORD_WIDTH-1:0];
              end
          LD_LAT:  lat_q <= wd[LAT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign cgra_cfg             = cgra_q;
  assign predrf_cfg           = pred_q;
  assign gprf_cfg             = gprf_q;
  assign cgra_compute_latency = lat_q;
  assign cfg_valid            = cfg_valid_q;
  assign busy                 = busy_w;
  assign err                  = err_q;
endmodule
